// File: rtl/pseudo_spi_scan_readback_pkg.sv
// Shared constants for the scan readback path: state encodings, slot phasing and default widths.
// The scan clock generator and the readback FSM both import this package.
package pseudo_spi_scan_readback_pkg;

  localparam int SLOT_PHASES = 4;
  localparam int PHASE_W     = $clog2(SLOT_PHASES);
  localparam int PH_SCLK1    = 1;
  localparam int PH_SCLK2    = 3;

  localparam int MEM_DATA_W  = 8;
  localparam int MEM_ADDR_W  = 9;
  localparam int DATA_LEN_W  = 8;

  typedef logic [2:0] spi_rb_state_t;

  localparam logic [2:0] SPI_RB_IDLE  = 3'd0;
  localparam logic [2:0] SPI_RB_CAPT  = 3'd1;
  localparam logic [2:0] SPI_RB_SHIFT = 3'd2;
  localparam logic [2:0] SPI_RB_WRITE = 3'd3;
  localparam logic [2:0] SPI_RB_DONE  = 3'd4;

  function automatic logic [PHASE_W-1:0] phase_next(input logic [PHASE_W-1:0] p);
    return (p == PHASE_W'(SLOT_PHASES - 1)) ? '0 : p + 1'b1;
  endfunction

endpackage

// File: rtl/pseudo_spi_scan_readback_scan_clk_gen.sv
// Scan clock slot generator: 4-phase slot with non-overlapping SCLK1/SCLK2 pulses.
// Pulses are registered so the scan chain never sees decode glitches.
module pseudo_spi_scan_readback_scan_clk_gen
  import pseudo_spi_scan_readback_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  output logic [PHASE_W-1:0] phase,
  output logic               sclk1,
  output logic               sclk2,
  output logic               slot_end
);

  // Outputs are set one edge early so the pulse lines up with its phase value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase <= '0;
      sclk1 <= 1'b0;
      sclk2 <= 1'b0;
    end else if (en) begin
      phase <= phase_next(phase);
      sclk1 <= (phase == PHASE_W'(PH_SCLK1 - 1));
      sclk2 <= (phase == PHASE_W'(PH_SCLK2 - 1));
    end else begin
      phase <= '0;
      sclk1 <= 1'b0;
      sclk2 <= 1'b0;
    end
  end

  assign slot_end = en && (phase == PHASE_W'(SLOT_PHASES - 1));

endmodule

// File: rtl/pseudo_spi_scan_readback.sv
// Captures scan-chain PIN values, shifts the chain out and stores it as words in the SRAM,
// writing from ADDR_BGN downward.
//   state | meaning
//   IDLE  | wait for BGN, latch start address and word count
//   CAPT  | SEL=1 for one slot, chain loads PIN
//   SHIFT | sample SPI_SI at phase 0, pulse scan clocks, 8 slots per word
//   WRITE | one-cycle SRAM write of the assembled word
//   DONE  | spi_is_done=1 until BGN returns low
module pseudo_spi_scan_readback
  import pseudo_spi_scan_readback_pkg::*;
#(
  parameter int MEMORY_DATA_WIDTH = MEM_DATA_W,
  parameter int MEMORY_ADDR_WIDTH = MEM_ADDR_W,
  parameter int RESERVED_DATA_LEN = DATA_LEN_W
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         BGN,
  input  logic [MEMORY_ADDR_WIDTH-1:0] ADDR_BGN,
  input  logic [RESERVED_DATA_LEN-1:0] DATA_LEN,
  input  logic                         SPI_SI,
  output logic                         SCLK1,
  output logic                         SCLK2,
  output logic                         SEL,
  output logic                         LAT,
  output logic                         CEN,
  output logic                         D_WE,
  output logic [MEMORY_ADDR_WIDTH-1:0] A,
  output logic [MEMORY_DATA_WIDTH-1:0] D,
  output logic                         spi_is_done
);

  localparam int BIT_W = $clog2(MEMORY_DATA_WIDTH);

  spi_rb_state_t                state;
  logic [PHASE_W-1:0]           phase;
  logic                         slot_end;
  logic                         clk_en;
  logic [BIT_W-1:0]             bit_cnt;
  logic [RESERVED_DATA_LEN-1:0] word_cnt;
  logic [MEMORY_DATA_WIDTH-1:0] shreg;

  assign clk_en = (state == SPI_RB_CAPT) || (state == SPI_RB_SHIFT);

  // Readback must never disturb the chain's parallel outputs.
  assign LAT = 1'b0;

  pseudo_spi_scan_readback_scan_clk_gen u_scan_clk_gen (
    .clk      (CLK),
    .rst      (RST),
    .en       (clk_en),
    .phase    (phase),
    .sclk1    (SCLK1),
    .sclk2    (SCLK2),
    .slot_end (slot_end)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= SPI_RB_IDLE;
      SEL         <= 1'b0;
      CEN         <= 1'b1;
      D_WE        <= 1'b0;
      A           <= '0;
      D           <= '0;
      spi_is_done <= 1'b0;
      bit_cnt     <= '0;
      word_cnt    <= '0;
      shreg       <= '0;
    end else begin
      CEN  <= 1'b1;
      D_WE <= 1'b0;
      case (state)
        SPI_RB_IDLE: begin
          if (BGN) begin
            A        <= ADDR_BGN;
            word_cnt <= DATA_LEN;
            SEL      <= 1'b1;
            state    <= SPI_RB_CAPT;
          end
        end
        SPI_RB_CAPT: begin
          if (slot_end) begin
            SEL     <= 1'b0;
            bit_cnt <= '0;
            state   <= SPI_RB_SHIFT;
          end
        end
        SPI_RB_SHIFT: begin
          // First bit out of the chain ends up in bit 0.
          if (phase == '0) begin
            shreg <= {SPI_SI, shreg[MEMORY_DATA_WIDTH-1:1]};
          end
          if (slot_end) begin
            if (bit_cnt == BIT_W'(MEMORY_DATA_WIDTH - 1)) begin
              bit_cnt <= '0;
              CEN     <= 1'b0;
              D_WE    <= 1'b1;
              D       <= shreg;
              state   <= SPI_RB_WRITE;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        SPI_RB_WRITE: begin
          if (word_cnt == '0) begin
            spi_is_done <= 1'b1;
            state       <= SPI_RB_DONE;
          end else begin
            word_cnt <= word_cnt - 1'b1;
            A        <= A - 1'b1;
            state    <= SPI_RB_SHIFT;
          end
        end
        SPI_RB_DONE: begin
          if (!BGN) begin
            spi_is_done <= 1'b0;
            state       <= SPI_RB_IDLE;
          end
        end
        default: begin
          SEL   <= 1'b0;
          state <= SPI_RB_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pseudo_spi_scan_readback.sv
// Bench for pseudo_spi_scan_readback: 14-cell scan chain model, behavioural SRAM,
// write scoreboard fed from a bit-stream reference model.
module tb_pseudo_spi_scan_readback;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       BGN = 1'b0;
  logic [8:0] ADDR_BGN = '0;
  logic [7:0] DATA_LEN = '0;
  logic       SPI_SI;
  logic       SCLK1, SCLK2, SEL, LAT, CEN, D_WE, spi_is_done;
  logic [8:0] A;
  logic [7:0] D;

  int vectors = 0;
  int errors  = 0;
  int sel_cnt = 0;

  logic [16:0] exp_q[$];
  logic [16:0] exp_e;
  logic [7:0]  mem [512];

  logic [13:0] pin_v  = '0;
  logic [13:0] master = '0;
  logic [13:0] slave  = '0;

  wire  [23:0] outs = {SCLK1, SCLK2, SEL, LAT, CEN, D_WE, A, D, spi_is_done};
  localparam logic [23:0] RESET_OUTS = {6'b000010, 9'd0, 8'd0, 1'b0};

  always #5 CLK = ~CLK;

  pseudo_spi_scan_readback dut (
    .CLK         (CLK),
    .RST         (RST),
    .BGN         (BGN),
    .ADDR_BGN    (ADDR_BGN),
    .DATA_LEN    (DATA_LEN),
    .SPI_SI      (SPI_SI),
    .SCLK1       (SCLK1),
    .SCLK2       (SCLK2),
    .SEL         (SEL),
    .LAT         (LAT),
    .CEN         (CEN),
    .D_WE        (D_WE),
    .A           (A),
    .D           (D),
    .spi_is_done (spi_is_done)
  );

  // Master/slave scan chain: bit 13 is the last cell, SIN tied low.
  always @(posedge SCLK1) master <= SEL ? pin_v : {slave[12:0], 1'b0};
  always @(posedge SCLK2) slave  <= master;
  assign SPI_SI = slave[13];

  // Monitor: SRAM model, write scoreboard and structural invariants.
  always @(negedge CLK) begin
    if (!RST) begin
      if (SCLK1 && SCLK2) begin
        errors++;
        $display("FAIL sclk_overlap SCLK1=%b SCLK2=%b required not both 1", SCLK1, SCLK2);
      end
      if (LAT !== 1'b0) begin
        errors++;
        $display("FAIL lat_low got %b required 0", LAT);
      end
      if ((CEN === 1'b0) !== (D_WE === 1'b1)) begin
        errors++;
        $display("FAIL strobe_pair CEN=%b D_WE=%b", CEN, D_WE);
      end
      if (SEL) sel_cnt++;
      if (CEN === 1'b0 && D_WE === 1'b1) begin
        vectors++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write addr=%0d data=%h required no write", A, D);
        end else begin
          exp_e = exp_q.pop_front();
          if ({A, D} !== exp_e) begin
            errors++;
            $display("FAIL sram_write got addr=%0d data=%h required addr=%0d data=%h",
                     A, D, exp_e[16:8], exp_e[7:0]);
          end
        end
        mem[A] = D;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h required %0h", name, got, exp);
    end
  endtask

  // Reference: the chain emits PIN[13] first down to PIN[0], then zeros from SIN.
  task automatic push_expected(input logic [13:0] pin, input logic [8:0] addr, input logic [7:0] len);
    logic [7:0] d;
    int k;
    for (int w = 0; w <= int'(len); w++) begin
      for (int b = 0; b < 8; b++) begin
        k = 8 * w + b;
        d[b] = (k < 14) ? pin[13 - k] : 1'b0;
      end
      exp_q.push_back({addr - 9'(w), d});
    end
  endtask

  task automatic run(input logic [13:0] pin, input logic [8:0] addr, input logic [7:0] len,
                     input bit drop_early, input bit hold_done);
    int cycles;
    pin_v    = pin;
    ADDR_BGN = addr;
    DATA_LEN = len;
    push_expected(pin, addr, len);
    @(negedge CLK);
    sel_cnt = 0;
    BGN = 1'b1;
    @(posedge CLK);
    #1;
    // Inputs are latched on start; scrambling them must not matter.
    ADDR_BGN = 9'($urandom);
    DATA_LEN = 8'($urandom);
    if (drop_early) BGN = 1'b0;
    cycles = 0;
    while (!spi_is_done && cycles < 5000) begin
      @(posedge CLK);
      #1;
      cycles++;
    end
    check("done_latency", 32'(cycles), 32'(4 + 33 * (int'(len) + 1)));
    check("sel_capt_cycles", 32'(sel_cnt), 32'd4);
    check("writes_outstanding", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    if (hold_done) begin
      repeat (40) @(posedge CLK);
      #1;
      check("done_held", 32'(spi_is_done), 32'd1);
    end
    @(negedge CLK);
    BGN = 1'b0;
    @(posedge CLK);
    #1;
    check("done_falls", 32'(spi_is_done), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [13:0] p6;
    logic [8:0]  a6;
    for (int i = 0; i < 512; i++) mem[i] = 8'hA5;

    repeat (3) @(posedge CLK);
    #1;
    check("reset_outputs", 32'(outs), 32'(RESET_OUTS));
    @(negedge CLK);
    RST = 1'b0;
    repeat (2) @(posedge CLK);

    run({10'd510, 4'b0000}, 9'd1, 8'd1, 1'b0, 1'b0);
    check("adc510_word1", 32'(mem[1]), 32'hFE);
    check("adc510_word0", 32'(mem[0]), 32'h01);

    run({10'h3FF, 4'b0001}, 9'd5, 8'd0, 1'b0, 1'b0);
    check("adc3ff_word", 32'(mem[5]), 32'hFF);
    check("addr4_untouched", 32'(mem[4]), 32'hA5);

    run(14'($urandom), 9'd0, 8'd1, 1'b0, 1'b0);
    run(14'($urandom), 9'($urandom), 8'd2, 1'b1, 1'b0);

    // Reset in the middle of the first word's shift.
    pin_v    = 14'($urandom);
    ADDR_BGN = 9'd100;
    DATA_LEN = 8'd2;
    @(negedge CLK);
    BGN = 1'b1;
    @(posedge CLK);
    #1;
    BGN = 1'b0;
    repeat (4 + 20) @(posedge CLK);
    #2;
    RST = 1'b1;
    #1;
    check("rst_mid_shift", 32'(outs), 32'(RESET_OUTS));
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("idle_after_rst", 32'(outs), 32'(RESET_OUTS));
    run(14'($urandom), 9'($urandom), 8'd1, 1'b0, 1'b0);

    p6 = 14'($urandom);
    a6 = 9'($urandom);
    run(p6, a6, 8'd1, 1'b0, 1'b1);
    run(p6, a6, 8'd1, 1'b0, 1'b0);

    for (int i = 0; i < 8; i++) begin
      run(14'($urandom), 9'($urandom), 8'($urandom_range(0, 4)), 1'($urandom), 1'b0);
    end

    repeat (4) @(posedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
